// File: rtl/uart_transceiver.sv
// rtl/uart_transceiver.sv - 8N1 UART with independent TX and RX sharing one baud divider.
// Define UART_FRAME_ERR_EN to add the o_frame_err pulse output.
module uart_transceiver #(
  parameter int FREQ = 1_000_000,
  parameter int RATE = 115_200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] i_data,
  input  logic       i_vld,
  output logic       o_tx_busy,
  output logic       o_tx,
  input  logic       i_rx,
  output logic [7:0] o_data,
`ifdef UART_FRAME_ERR_EN
  output logic       o_frame_err,
`endif
  output logic       o_vld
);

  localparam int DIV = FREQ / RATE;
  localparam int CW  = $clog2(DIV);
  localparam logic [CW-1:0] BIT_END  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_END = CW'(DIV / 2 - 1);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_IDLE} rx_state_t;

  tx_state_t     tx_state, tx_next;
  logic [CW-1:0] tx_cnt;
  logic [2:0]    tx_bit;
  logic [7:0]    tx_shift;
  logic          tx_end;

  rx_state_t     rx_state, rx_next;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_shift;
  logic          rx_meta, rx_sync;
  logic          rx_end, rx_half;

  assign tx_end  = (tx_cnt == BIT_END);
  assign rx_end  = (rx_cnt == BIT_END);
  assign rx_half = (rx_cnt == HALF_END);

  always_comb begin
    tx_next = tx_state;
    case (tx_state)
      TX_IDLE:  if (i_vld) tx_next = TX_START;
      TX_START: if (tx_end) tx_next = TX_DATA;
      TX_DATA:  if (tx_end && tx_bit == 3'd7) tx_next = TX_STOP;
      TX_STOP:  if (tx_end) tx_next = TX_IDLE;
      default:  tx_next = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tx_state <= TX_IDLE;
    else        tx_state <= tx_next;
  end

  // o_tx is updated one bit ahead so the line changes exactly on bit boundaries
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_cnt    <= '0;
      tx_bit    <= '0;
      tx_shift  <= '0;
      o_tx      <= 1'b1;
      o_tx_busy <= 1'b0;
    end else begin
      o_tx_busy <= (tx_next != TX_IDLE);
      if (tx_state == TX_IDLE) begin
        tx_cnt <= '0;
        tx_bit <= '0;
        if (i_vld) begin
          tx_shift <= i_data;
          o_tx     <= 1'b0;
        end
      end else begin
        tx_cnt <= tx_end ? '0 : tx_cnt + CW'(1);
        if (tx_end) begin
          case (tx_state)
            TX_START: o_tx <= tx_shift[0];
            TX_DATA: begin
              tx_bit   <= tx_bit + 3'd1;
              o_tx     <= (tx_bit == 3'd7) ? 1'b1 : tx_shift[1];
              tx_shift <= {1'b0, tx_shift[7:1]};
            end
            default: ;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= i_rx;
      rx_sync <= rx_meta;
    end
  end

  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      RX_IDLE:      if (!rx_sync) rx_next = RX_START;
      RX_START:     if (rx_half) rx_next = rx_sync ? RX_IDLE : RX_DATA;
      RX_DATA:      if (rx_end && rx_bit == 3'd7) rx_next = RX_STOP;
      RX_STOP:      if (rx_end) rx_next = rx_sync ? RX_IDLE : RX_WAIT_IDLE;
      RX_WAIT_IDLE: if (rx_sync) rx_next = RX_IDLE;
      default:      rx_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rx_state <= RX_IDLE;
    else        rx_state <= rx_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_cnt      <= '0;
      rx_bit      <= '0;
      rx_shift    <= '0;
      o_data      <= '0;
      o_vld       <= 1'b0;
`ifdef UART_FRAME_ERR_EN
      o_frame_err <= 1'b0;
`endif
    end else begin
      o_vld       <= 1'b0;
`ifdef UART_FRAME_ERR_EN
      o_frame_err <= 1'b0;
`endif
      case (rx_state)
        RX_START: rx_cnt <= rx_half ? '0 : rx_cnt + CW'(1);
        RX_DATA: begin
          rx_cnt <= rx_end ? '0 : rx_cnt + CW'(1);
          if (rx_end) begin
            rx_shift <= {rx_sync, rx_shift[7:1]};
            rx_bit   <= rx_bit + 3'd1;
          end
        end
        RX_STOP: begin
          rx_cnt <= rx_end ? '0 : rx_cnt + CW'(1);
          if (rx_end && rx_sync) begin
            o_data <= rx_shift;
            o_vld  <= 1'b1;
          end
`ifdef UART_FRAME_ERR_EN
          if (rx_end && !rx_sync) o_frame_err <= 1'b1;
`endif
        end
        default: begin
          rx_cnt <= '0;
          rx_bit <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_transceiver.sv
// tb/tb_uart_transceiver.sv - directed bench for uart_transceiver (loopback and driven RX line).
module tb_uart_transceiver;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] i_data = 8'h00;
  logic       i_vld = 1'b0;
  logic       o_tx_busy, o_tx, i_rx, o_vld;
  logic [7:0] o_data;
  logic       loop = 1'b1;
  logic       rx_drv = 1'b1;
`ifdef UART_FRAME_ERR_EN
  logic       o_frame_err;
  int         ferr_total = 0;
`endif

  int checks = 0;
  int errors = 0;
  int vld_total = 0;
  logic [7:0] last_rx = 8'h00;

  assign i_rx = loop ? o_tx : rx_drv;

  always #5 clk = ~clk;

  uart_transceiver dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_data    (i_data),
    .i_vld     (i_vld),
    .o_tx_busy (o_tx_busy),
    .o_tx      (o_tx),
    .i_rx      (i_rx),
    .o_data    (o_data),
`ifdef UART_FRAME_ERR_EN
    .o_frame_err(o_frame_err),
`endif
    .o_vld     (o_vld)
  );

  always @(negedge clk) begin
    if (o_vld) begin
      vld_total++;
      last_rx = o_data;
    end
`ifdef UART_FRAME_ERR_EN
    if (o_frame_err) ferr_total++;
`endif
  end

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;
    logic [7:0] exp_rx;
    logic       inject;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Called on a falling edge; returns on the falling edge right after o_tx_busy should drop.
  task automatic send_lb(input vec_t v);
    int nv;
    int vc;
    logic [9:0] got;
    logic [7:0] rxd;
    nv = 0; vc = 0; got = '0; rxd = 8'h00;
    i_data = v.data;
    i_vld  = 1'b1;
    @(posedge clk);
    #1 i_vld = 1'b0;
    for (int c = 1; c <= 81; c++) begin
      @(negedge clk);
      if (v.inject && c == 20) begin
        i_data = 8'h55;
        i_vld  = 1'b1;
      end
      if (v.inject && c == 21) i_vld = 1'b0;
      if ((c - 1) % 8 == 4) got = {o_tx, got[9:1]};
      if (o_vld) begin
        nv++;
        vc  = c;
        rxd = o_data;
      end
      if (c == 1)  chk("busy_rise", 32'(o_tx_busy), 32'd1);
      if (c == 80) chk("busy_last", 32'(o_tx_busy), 32'd1);
      if (c == 81) chk("busy_fall", 32'(o_tx_busy), 32'd0);
    end
    chk("tx_frame", 32'(got), 32'(v.frame));
    chk("vld_count", 32'(nv), 32'd1);
    chk("rx_data", 32'(rxd), 32'(v.exp_rx));
    chk("latency_in_range", 32'(vc >= 70 && vc <= 85), 32'd1);
  endtask

  task automatic drive_frame(input logic [9:0] f);
    for (int i = 0; i < 10; i++) begin
      rx_drv = f[i];
      repeat (8) @(negedge clk);
    end
  endtask

  initial begin
    // frame bits listed stop..start so bit 0 is the first on the line
    vecs[0] = '{data: 8'h6A, frame: 10'b1_01101010_0, exp_rx: 8'h6A, inject: 1'b0};
    vecs[1] = '{data: 8'h00, frame: 10'b1_00000000_0, exp_rx: 8'h00, inject: 1'b0};
    vecs[2] = '{data: 8'hFF, frame: 10'b1_11111111_0, exp_rx: 8'hFF, inject: 1'b0};
    vecs[3] = '{data: 8'hA3, frame: 10'b1_10100011_0, exp_rx: 8'hA3, inject: 1'b1};

    repeat (3) @(negedge clk);
    chk("rst_tx", 32'(o_tx), 32'd1);
    chk("rst_busy", 32'(o_tx_busy), 32'd0);
    chk("rst_data", 32'(o_data), 32'd0);
    chk("rst_vld", 32'(o_vld), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int k = 0; k < 4; k++) send_lb(vecs[k]);

    repeat (10) @(negedge clk);
    chk("drop_no_requeue", 32'(o_tx_busy), 32'd0);
    chk("drop_vld_total", 32'(vld_total), 32'd4);
    chk("drop_last_rx", 32'(last_rx), 32'hA3);

    loop = 1'b0;
    rx_drv = 1'b0;
    repeat (2) @(negedge clk);
    rx_drv = 1'b1;
    repeat (20) @(negedge clk);
    chk("false_start_vld", 32'(vld_total), 32'd4);
    chk("false_start_data", 32'(o_data), 32'hA3);

    drive_frame(10'b1_00111100_0);
    repeat (30) @(negedge clk);
    chk("after_false_vld", 32'(vld_total), 32'd5);
    chk("after_false_data", 32'(last_rx), 32'h3C);

    drive_frame(10'b0_10000001_0);
    repeat (16) @(negedge clk);
    rx_drv = 1'b1;
    repeat (30) @(negedge clk);
    chk("frame_err_no_vld", 32'(vld_total), 32'd5);
    chk("frame_err_data_held", 32'(o_data), 32'h3C);
`ifdef UART_FRAME_ERR_EN
    chk("frame_err_pulse", 32'(ferr_total), 32'd1);
`endif

    drive_frame(10'b1_01000010_0);
    repeat (30) @(negedge clk);
    chk("after_ferr_vld", 32'(vld_total), 32'd6);
    chk("after_ferr_data", 32'(last_rx), 32'h42);

    loop = 1'b1;
    repeat (4) @(negedge clk);
    i_data = 8'h6A;
    i_vld  = 1'b1;
    @(posedge clk);
    #1 i_vld = 1'b0;
    repeat (44) @(negedge clk);
    chk("pre_reset_bit4_low", 32'(o_tx), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("reset_tx_high", 32'(o_tx), 32'd1);
    chk("reset_busy", 32'(o_tx_busy), 32'd0);
    chk("reset_data", 32'(o_data), 32'd0);
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    chk("reset_no_vld", 32'(vld_total), 32'd6);
    chk("reset_tx_idle", 32'(o_tx), 32'd1);
    send_lb(vecs[0]);
    repeat (10) @(negedge clk);
    chk("final_vld_total", 32'(vld_total), 32'd7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
